// File: rtl/ofifo.sv
// Output FIFO bank: one FIFO per array column, popped a full row at a time.
// Columns fill skewed; a row becomes visible once every column holds an entry.
module ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_out_valid,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    localparam int AW = $clog2(depth);

    logic [col-1:0][AW:0]   wr_ptr;
    logic [col-1:0][AW:0]   rd_ptr;
    logic [col-1:0]         full_c;
    logic [col-1:0]         nempty_c;
    logic [col-1:0]         wr_ok;
    logic                   pop;
    logic [psum_bw-1:0]     mem [col][depth];

    // Status comes from registered pointers only, never from wr/rd/in.
    always_comb begin
        full_c   = '0;
        nempty_c = '0;
        for (int c = 0; c < col; c++) begin
            full_c[c]   = (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]) &&
                          (wr_ptr[c][AW] != rd_ptr[c][AW]);
            nempty_c[c] = (wr_ptr[c] != rd_ptr[c]);
        end
    end

    assign o_valid = &nempty_c;
    assign o_full  = |full_c;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // A full column still accepts when the row pops in the same cycle.
    always_comb begin
        wr_ok = '0;
        for (int c = 0; c < col; c++)
            wr_ok[c] = wr[c] & (~full_c[c] | pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out         <= '0;
            o_out_valid <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_out_valid <= pop;
            for (int c = 0; c < col; c++) begin
                if (pop) begin
                    rd_ptr[c]                  <= rd_ptr[c] + 1'b1;
                    out[psum_bw*c +: psum_bw]  <= mem[c][rd_ptr[c][AW-1:0]];
                end
                if (wr_ok[c])
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                else if (wr[c])
                    o_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++)
            if (!reset && wr_ok[c])
                mem[c][wr_ptr[c][AW-1:0]] <= in[psum_bw*c +: psum_bw];
    end

endmodule
